// File: rtl/transparency_fade_controller.sv
// transparency_fade_controller
// Walks the blend proportion one LSB per step toward a commanded target.
// Updates are taken only on frame_start, so each frame shows one proportion.
// Optional build macro TRANSPARENCY_FADE_RETARGET_EN: when defined, a new
// command can be accepted during a fade and retargets it from the current value.
module transparency_fade_controller #(
  parameter int TRANSPARENCY_PRECISION = 3,
  parameter int STEP_COUNT_WIDTH       = 8,
  parameter int RESET_PROPORTION       = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame_start,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [TRANSPARENCY_PRECISION-1:0] cmd_target,
  input  logic [STEP_COUNT_WIDTH-1:0]       cmd_frames_per_step,
  output logic [TRANSPARENCY_PRECISION-1:0] src_a_proportion,
  output logic                              fade_busy,
  output logic                              fade_done
);

  localparam int P = TRANSPARENCY_PRECISION;
  localparam int S = STEP_COUNT_WIDTH;
  localparam logic [P-1:0] RESET_VAL = RESET_PROPORTION[P-1:0];
  localparam logic [P-1:0] PROP_ONE  = {{(P-1){1'b0}}, 1'b1};
  localparam logic [S-1:0] CNT_ONE   = {{(S-1){1'b0}}, 1'b1};
  localparam logic [S-1:0] CNT_ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [P-1:0]   prop_q, prop_d;
  logic [P-1:0]   target_q, target_d;
  logic [S-1:0]   rate_q, rate_d;
  logic [S-1:0]   cnt_q, cnt_d;
  logic           cmd_accept;
  logic [P-1:0]   prop_step;
  logic           step_due;

  // Ready decode: IDLE always, FADE too when retargeting is built in
  always_comb begin
    cmd_ready = (state_q == IDLE);
`ifdef TRANSPARENCY_FADE_RETARGET_EN
    if (state_q == FADE) cmd_ready = 1'b1;
`endif
  end

  assign cmd_accept       = cmd_valid && cmd_ready;
  assign src_a_proportion = prop_q;
  assign fade_busy        = (state_q == FADE);
  assign fade_done        = (state_q == DONE);

  // Next one-LSB value toward the latched target; the compare keeps it from wrapping
  always_comb begin
    prop_step = prop_q;
    if (prop_q < target_q)      prop_step = prop_q + PROP_ONE;
    else if (prop_q > target_q) prop_step = prop_q - PROP_ONE;
    step_due = (cnt_q == (rate_q - CNT_ONE));
  end

  // Next-state, proportion, counter and command latch
  always_comb begin
    state_d  = state_q;
    prop_d   = prop_q;
    target_d = target_q;
    rate_d   = rate_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          target_d = cmd_target;
          rate_d   = cmd_frames_per_step;
          cnt_d    = CNT_ZERO;
          state_d  = (cmd_target == prop_q) ? DONE : FADE;
        end
      end
      FADE: begin
`ifdef TRANSPARENCY_FADE_RETARGET_EN
        // A retarget takes priority; a frame pulse in the same cycle is dropped
        if (cmd_accept) begin
          target_d = cmd_target;
          rate_d   = cmd_frames_per_step;
          cnt_d    = CNT_ZERO;
          state_d  = (cmd_target == prop_q) ? DONE : FADE;
        end else
`endif
        if (frame_start) begin
          if (rate_q == CNT_ZERO) begin
            prop_d  = target_q;
            state_d = DONE;
          end else if (step_due) begin
            prop_d = prop_step;
            cnt_d  = CNT_ZERO;
            if (prop_step == target_q) state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state, output proportion and frame counter, cleared by async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prop_q  <= RESET_VAL;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      prop_q  <= prop_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched command fields; only read while a fade is in progress
  always_ff @(posedge clk) begin
    target_q <= target_d;
    rate_q   <= rate_d;
  end

endmodule

// File: tb/tb_transparency_fade_controller.sv
// Directed bench for transparency_fade_controller (default parameters).
module tb_transparency_fade_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_target;
  logic [7:0] cmd_frames_per_step;
  logic [2:0] src_a_proportion;
  logic       fade_busy;
  logic       fade_done;

  int total = 0;
  int bad   = 0;
  int done_seen;

  transparency_fade_controller dut (
    .clk                 (clk),
    .rst                 (rst),
    .frame_start         (frame_start),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_target          (cmd_target),
    .cmd_frames_per_step (cmd_frames_per_step),
    .src_a_proportion    (src_a_proportion),
    .fade_busy           (fade_busy),
    .fade_done           (fade_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (fade_done) done_seen++;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_cmd(input int t, input int r);
    cmd_valid           = 1'b1;
    cmd_target          = 3'(t);
    cmd_frames_per_step = 8'(r);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; cmd_valid = 1'b0;
    cmd_target = '0; cmd_frames_per_step = '0; done_seen = 0;
    repeat (2) tick();
    chk("reset_prop", src_a_proportion, 0);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_busy", fade_busy, 0);
    chk("reset_done", fade_done, 0);
    rst = 1'b0;
    tick();

    // Idle frames are ignored
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin pulse_frame(); tick(); end
    chk("idle_prop", src_a_proportion, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy", fade_busy, 0);
    chk("idle_done_count", done_seen, 0);

    // 0 -> 4 at two frames per step
    send_cmd(4, 2);
    chk("up_accept_busy", fade_busy, 1);
    chk("up_accept_ready", cmd_ready, 0);
    chk("up_accept_prop", src_a_proportion, 0);
    done_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      pulse_frame();
      chk($sformatf("up_prop_f%0d", k), src_a_proportion, k / 2);
      if (k < 8) chk($sformatf("up_busy_f%0d", k), fade_busy, 1);
    end
    chk("up_done", fade_done, 1);
    chk("up_done_busy", fade_busy, 0);
    tick();
    chk("up_done_clear", fade_done, 0);
    chk("up_ready_back", cmd_ready, 1);
    chk("up_done_count", done_seen, 1);

    // 4 -> 1 at one frame per step, consecutive frames
    send_cmd(1, 1);
    for (int k = 1; k <= 3; k++) begin
      pulse_frame();
      chk($sformatf("down_prop_f%0d", k), src_a_proportion, 4 - k);
    end
    chk("down_done", fade_done, 1);
    tick();
    pulse_frame();
    chk("down_hold_prop", src_a_proportion, 1);
    chk("down_hold_done", fade_done, 0);

    // 1 -> 6 jump; frame in the accept cycle does not count
    frame_start = 1'b1;
    send_cmd(6, 0);
    frame_start = 1'b0;
    chk("jump_accept_prop", src_a_proportion, 1);
    chk("jump_accept_busy", fade_busy, 1);
    tick();
    chk("jump_wait_prop", src_a_proportion, 1);
    pulse_frame();
    chk("jump_prop", src_a_proportion, 6);
    chk("jump_done", fade_done, 1);
    tick();

    // 6 -> 7 stops at the top endpoint
    send_cmd(7, 1);
    pulse_frame();
    chk("top_prop", src_a_proportion, 7);
    chk("top_done", fade_done, 1);
    tick();
    pulse_frame();
    chk("top_hold_prop", src_a_proportion, 7);

    // Command equal to current value: DONE with no frame
    send_cmd(7, 3);
    chk("eq_done", fade_done, 1);
    chk("eq_busy", fade_busy, 0);
    chk("eq_prop", src_a_proportion, 7);
    tick();
    chk("eq_done_clear", fade_done, 0);
    chk("eq_ready", cmd_ready, 1);

    // Reset mid-fade at value 3
    send_cmd(0, 1);
    for (int k = 0; k < 4; k++) pulse_frame();
    chk("rstfade_prop_before", src_a_proportion, 3);
    done_seen = 0;
    #2 rst = 1'b1;
    #1;
    chk("rstfade_prop_async", src_a_proportion, 0);
    chk("rstfade_busy", fade_busy, 0);
    chk("rstfade_done", fade_done, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin pulse_frame(); tick(); end
    chk("rstfade_done_count", done_seen, 0);
    chk("rstfade_ready", cmd_ready, 1);
    chk("rstfade_prop_after", src_a_proportion, 0);

`ifdef TRANSPARENCY_FADE_RETARGET_EN
    // 0 -> 7 retargeted to 2 at value 5
    send_cmd(7, 1);
    for (int k = 0; k < 5; k++) pulse_frame();
    chk("rt_prop5", src_a_proportion, 5);
    chk("rt_ready_fade", cmd_ready, 1);
    done_seen = 0;
    send_cmd(2, 1);
    chk("rt_accept_prop", src_a_proportion, 5);
    chk("rt_accept_busy", fade_busy, 1);
    for (int k = 1; k <= 3; k++) begin
      pulse_frame();
      chk($sformatf("rt_prop_f%0d", k), src_a_proportion, 5 - k);
    end
    chk("rt_done", fade_done, 1);
    tick();
    chk("rt_done_count", done_seen, 1);
`else
    // Second command held during a fade waits until after DONE
    send_cmd(7, 1);
    pulse_frame();
    pulse_frame();
    chk("wait_prop2", src_a_proportion, 2);
    chk("wait_ready_fade", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_target = 3'd3; cmd_frames_per_step = 8'd0;
    for (int k = 3; k <= 7; k++) begin
      pulse_frame();
      chk($sformatf("wait_prop_f%0d", k), src_a_proportion, k);
    end
    chk("wait_done", fade_done, 1);
    chk("wait_ready_done", cmd_ready, 0);
    tick();
    chk("wait_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("wait_accepted_busy", fade_busy, 1);
    chk("wait_accepted_prop", src_a_proportion, 7);
    pulse_frame();
    chk("wait_jump_prop", src_a_proportion, 3);
    chk("wait_jump_done", fade_done, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
